// File: rtl/psum_drain_ctrl_if.sv
`default_nettype none
// ============================================================================
// psum_drain_ctrl_if : host start/stream and psum SRAM control bundle
// Rev 1.0
// ============================================================================
interface psum_drain_ctrl_if #(
  parameter int ADR_P  = 11,
  parameter int SRAM_P = 32
);
  logic              i_start;
  logic              i_abort;
  logic [ADR_P-1:0]  i_base_addr;
  logic [ADR_P:0]    i_num_rows;
  logic              o_busy;
  logic              o_done;
  logic              o_out;
  logic [ADR_P-1:0]  o_addr;
  logic [5:0]        o_bank_sel;
  logic [SRAM_P-1:0] i_rdata;
  logic [SRAM_P-1:0] o_data;
  logic              o_valid;
  logic              i_ready;
  logic              o_last;

  modport master (
    input  i_start, i_abort, i_base_addr, i_num_rows, i_rdata, i_ready,
    output o_busy, o_done, o_out, o_addr, o_bank_sel, o_data, o_valid, o_last
  );

  modport slave (
    output i_start, i_abort, i_base_addr, i_num_rows, i_rdata, i_ready,
    input  o_busy, o_done, o_out, o_addr, o_bank_sel, o_data, o_valid, o_last
  );
endinterface
`default_nettype wire

// File: rtl/psum_drain_ctrl.sv
`default_nettype none
// ============================================================================
// psum_drain_ctrl : walks psum SRAM rows/banks and streams words to the host
// Rev 1.0
// ============================================================================
module psum_drain_ctrl #(
  parameter int ADR_P   = 11,
  parameter int SRAM_P  = 32,
  parameter int N_BANKS = 32,
  parameter int RD_LAT  = 1
) (
  input  wire logic           i_clk,
  input  wire logic           i_rst,
  psum_drain_ctrl_if.master   bus
);
  localparam int         c_ROW_W     = ADR_P + 1;
  localparam logic [1:0] c_IDLE      = 2'd0;
  localparam logic [1:0] c_WAIT      = 2'd1;
  localparam logic [1:0] c_STREAM    = 2'd2;
  localparam logic [1:0] c_DONE      = 2'd3;
  localparam logic [5:0] c_LAST_BANK = 6'(N_BANKS - 1);
  localparam logic [1:0] c_WAIT_END  = 2'(RD_LAT - 1);

  logic [1:0]         r_state;
  logic [1:0]         r_wait;
  logic [c_ROW_W-1:0] r_rows;
  logic [ADR_P-1:0]   r_addr;
  logic [5:0]         r_bank;
  logic               r_out;
  logic               r_valid;
  logic [SRAM_P-1:0]  w_data;
  logic               w_hs;
  logic               w_last_bank;

  assign w_data      = bus.i_rdata;
  assign w_hs        = r_valid && bus.i_ready;
  assign w_last_bank = (r_bank == c_LAST_BANK);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= c_IDLE;
      r_wait  <= '0;
      r_rows  <= '0;
      r_addr  <= '0;
      r_bank  <= '0;
      r_out   <= 1'b0;
      r_valid <= 1'b0;
    end else if (r_state != c_IDLE && bus.i_abort) begin
      // abort outranks any handshake in the same cycle
      r_state <= c_IDLE;
      r_wait  <= '0;
      r_bank  <= '0;
      r_out   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (bus.i_start) begin
            if (bus.i_num_rows != '0) begin
              r_rows  <= bus.i_num_rows;
              r_addr  <= bus.i_base_addr;
              r_bank  <= '0;
              r_wait  <= '0;
              r_out   <= 1'b1;
              r_state <= c_WAIT;
            end else begin
              r_state <= c_DONE;
            end
          end
        end
        c_WAIT: begin
          if (r_wait == c_WAIT_END) begin
            r_valid <= 1'b1;
            r_state <= c_STREAM;
          end else begin
            r_wait <= r_wait + 2'd1;
          end
        end
        c_STREAM: begin
          if (w_hs) begin
            if (!w_last_bank) begin
              r_bank <= r_bank + 6'd1;
            end else if (r_rows != c_ROW_W'(1)) begin
              // next row needs a fresh SRAM read, hence the WAIT bubble
              r_addr  <= r_addr + 1'b1;
              r_bank  <= '0;
              r_rows  <= r_rows - 1'b1;
              r_wait  <= '0;
              r_valid <= 1'b0;
              r_state <= c_WAIT;
            end else begin
              r_valid <= 1'b0;
              r_out   <= 1'b0;
              r_state <= c_DONE;
            end
          end
        end
        default: begin
          r_out   <= 1'b0;
          r_valid <= 1'b0;
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign bus.o_busy     = (r_state != c_IDLE);
  assign bus.o_done     = (r_state == c_DONE);
  assign bus.o_out      = r_out;
  assign bus.o_addr     = r_addr;
  assign bus.o_bank_sel = r_bank;
  assign bus.o_data     = w_data;
  assign bus.o_valid    = r_valid;
  assign bus.o_last     = r_valid && w_last_bank && (r_rows == c_ROW_W'(1));
endmodule
`default_nettype wire

// File: tb/tb_psum_drain_ctrl.sv
`default_nettype none
// ============================================================================
// tb_psum_drain_ctrl : directed checks of psum_drain_ctrl with a psum SRAM model
// Rev 1.0
// ============================================================================
module tb_psum_drain_ctrl;
  localparam int c_NB = 32;

  logic i_clk;
  logic i_rst;
  logic [10:0] r_row_q;
  int n_total;
  int n_pass;

  psum_drain_ctrl_if #(.ADR_P(11), .SRAM_P(32)) bus ();

  psum_drain_ctrl #(.ADR_P(11), .SRAM_P(32), .N_BANKS(c_NB), .RD_LAT(1)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // psum SRAM: row latched one cycle after address, bank mux combinational
  always @(posedge i_clk) r_row_q <= bus.o_addr;
  assign bus.i_rdata = {5'd0, r_row_q, 10'd0, bus.o_bank_sel};

  function automatic logic [31:0] mk(input logic [10:0] a, input logic [5:0] b);
    return {5'd0, a, 10'd0, b};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic drain(input logic [10:0] base, input int rows, input bit rnd,
                       input int abort_idx, input int glitch_cyc, input int rst_cyc);
    int idx = 0;
    int cyc = 0;
    int first = -1;
    int done_cyc = -1;
    int total = rows * c_NB;
    bit ended = 0;
    logic [10:0] ea;
    logic [5:0]  eb;
    bus.i_start     = 1'b1;
    bus.i_base_addr = base;
    bus.i_num_rows  = 12'(rows);
    bus.i_ready     = 1'b1;
    @(negedge i_clk);
    bus.i_start = 1'b0;
    cyc = 1;
    while (!ended && cyc < 4000) begin
      bus.i_ready     = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.i_start     = (cyc == glitch_cyc);
      bus.i_num_rows  = (cyc == glitch_cyc) ? 12'd1 : 12'(rows);
      bus.i_base_addr = (cyc == glitch_cyc) ? 11'h3FF : base;
      ea = 11'(base + 11'(idx / c_NB));
      eb = 6'(idx % c_NB);
      if (bus.o_valid && first < 0) first = cyc;
      if (bus.o_done) begin
        done_cyc = cyc;
        ended = 1;
        chk("done_out", bus.o_out, 0);
        chk("done_valid", bus.o_valid, 0);
        chk("done_busy", bus.o_busy, 1);
        chk("word_count", idx, total);
        if (!rnd) chk("done_cycle", done_cyc, 1 + rows * (1 + c_NB));
        @(negedge i_clk);
        chk("post_done_busy", bus.o_busy, 0);
        chk("post_done_done", bus.o_done, 0);
        chk("post_done_out", bus.o_out, 0);
      end else if (cyc == rst_cyc) begin
        ended = 1;
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("rst_busy", bus.o_busy, 0);
        chk("rst_done", bus.o_done, 0);
        chk("rst_out", bus.o_out, 0);
        chk("rst_valid", bus.o_valid, 0);
        chk("rst_last", bus.o_last, 0);
        chk("rst_addr", bus.o_addr, 0);
        chk("rst_bank", bus.o_bank_sel, 0);
        i_rst = 1'b0;
      end else if (bus.o_valid && idx == abort_idx) begin
        ended = 1;
        bus.i_abort = 1'b1;
        @(negedge i_clk);
        bus.i_abort = 1'b0;
        chk("abort_busy", bus.o_busy, 0);
        chk("abort_out", bus.o_out, 0);
        chk("abort_valid", bus.o_valid, 0);
        chk("abort_bank", bus.o_bank_sel, 0);
        for (int k = 0; k < 3; k++) begin
          chk("abort_no_done", bus.o_done, 0);
          @(negedge i_clk);
        end
      end else if (bus.o_valid) begin
        chk("data", bus.o_data, mk(ea, eb));
        chk("addr", bus.o_addr, ea);
        chk("bank", bus.o_bank_sel, eb);
        chk("last", bus.o_last, (idx == total - 1));
        chk("out_stream", bus.o_out, 1);
        if (bus.i_ready) idx++;
      end else begin
        chk("wait_out", bus.o_out, 1);
        chk("wait_busy", bus.o_busy, 1);
      end
      if (!ended) begin
        @(negedge i_clk);
        cyc++;
      end
    end
    if (!ended) chk("timeout", cyc, 0);
    if (!rnd && first >= 0) chk("first_valid_lat", first, 2);
    bus.i_start = 1'b0;
    bus.i_ready = 1'b1;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    i_rst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    bus.i_base_addr = '0;
    bus.i_num_rows = '0;
    bus.i_ready = 1'b1;
    repeat (3) @(negedge i_clk);
    chk("reset_busy", bus.o_busy, 0);
    chk("reset_done", bus.o_done, 0);
    chk("reset_out", bus.o_out, 0);
    chk("reset_valid", bus.o_valid, 0);
    chk("reset_last", bus.o_last, 0);
    chk("reset_addr", bus.o_addr, 0);
    chk("reset_bank", bus.o_bank_sel, 0);
    i_rst = 1'b0;
    @(negedge i_clk);

    // zero rows: straight to DONE, no SRAM ownership
    bus.i_start = 1'b1;
    bus.i_base_addr = 11'h155;
    bus.i_num_rows = '0;
    @(negedge i_clk);
    bus.i_start = 1'b0;
    chk("zero_done", bus.o_done, 1);
    chk("zero_busy", bus.o_busy, 1);
    chk("zero_out", bus.o_out, 0);
    chk("zero_valid", bus.o_valid, 0);
    chk("zero_addr", bus.o_addr, 0);
    @(negedge i_clk);
    chk("zero_done_end", bus.o_done, 0);
    chk("zero_busy_end", bus.o_busy, 0);
    chk("zero_addr_end", bus.o_addr, 0);
    @(negedge i_clk);

    drain(11'h010, 2, 0, -1, -1, -1);
    drain(11'h100, 3, 1, -1, -1, -1);
    drain(11'h7FF, 2, 0, -1, -1, -1);
    drain(11'h040, 2, 0, 5, -1, -1);
    drain(11'h020, 1, 0, -1, -1, -1);
    drain(11'h0A0, 2, 0, -1, 10, -1);
    drain(11'h0B0, 2, 0, -1, -1, 12);
    drain(11'h0C0, 1, 0, -1, -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
`default_nettype wire
